// File: rtl/seq_detector.sv
// -----------------------------------------------------------------------------
// seq_detector
//   Serial pattern detector. One bit of istream is shifted into a PLEN-bit
//   history on every accepted cycle (in_valid=1, cfg_load=0) and compared
//   against a run-time reloadable pattern. Bit 0 of the pattern and of the
//   history is the most recently received bit.
//
//   Matches can overlap (history keeps counting) or not overlap (a match
//   consumes its bits and the fill level restarts from zero). Every match
//   raises ostream for one cycle, on the edge after the matching bit, and
//   bumps a saturating match counter.
//
// Ports
//   clk         in   1        clock, all logic on posedge
//   rst         in   1        synchronous reset, active-high, overrides all
//   in_valid    in   1        istream carries a valid bit this cycle
//   istream     in   1        serial data bit
//   cfg_load    in   1        load cfg_pattern / cfg_overlap, clear history
//   cfg_pattern in   PLEN     new pattern
//   cfg_overlap in   1        new mode (1 = overlapping matches)
//   cnt_clr     in   1        clear match_cnt (wins over a same-cycle hit)
//   ostream     out  1        one-cycle match pulse
//   match_cnt   out  CNT_W    saturating match count
//   fill        out  FILL_W   bits held in history, saturates at PLEN
// -----------------------------------------------------------------------------
module seq_detector #(
    parameter int              PLEN    = 4,
    parameter logic [PLEN-1:0] PATTERN = 4'b1111,
    parameter bit              OVERLAP = 1'b1,
    parameter int              CNT_W   = 8,
    parameter int              FILL_W  = $clog2(PLEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              istream,
    input  logic              cfg_load,
    input  logic [PLEN-1:0]   cfg_pattern,
    input  logic              cfg_overlap,
    input  logic              cnt_clr,
    output logic              ostream,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [FILL_W-1:0] fill
);

    localparam logic [FILL_W-1:0] FILL_MAX_C  = FILL_W'(PLEN);
    localparam logic [FILL_W-1:0] FILL_HIT_C  = FILL_W'(PLEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX_C   = {CNT_W{1'b1}};

    logic [PLEN-1:0]   hist_r;
    logic [PLEN-1:0]   pattern_r;
    logic              overlap_r;
    logic [FILL_W-1:0] fill_r;
    logic              ostream_r;
    logic [CNT_W-1:0]  match_cnt_r;

    logic              accept_s;
    logic [PLEN-1:0]   next_s;
    logic              hit_s;
    logic [FILL_W-1:0] fill_nxt_s;

    // Candidate history, hit decision and next fill level for the current bit.
    always_comb begin
        accept_s   = in_valid & ~cfg_load;
        next_s     = {hist_r[PLEN-2:0], istream};
        hit_s      = 1'b0;
        fill_nxt_s = fill_r;
        if (accept_s) begin
            // fill >= PLEN-1 means this bit completes a full window of real data.
            hit_s = (fill_r >= FILL_HIT_C) && (next_s == pattern_r);
            if (hit_s && !overlap_r) begin
                fill_nxt_s = {FILL_W{1'b0}};
            end else if (fill_r == FILL_MAX_C) begin
                fill_nxt_s = fill_r;
            end else begin
                fill_nxt_s = fill_r + FILL_W'(1);
            end
        end else begin
            hit_s      = 1'b0;
            fill_nxt_s = fill_r;
        end
    end

    // History, fill, configuration and match pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_r    <= {PLEN{1'b0}};
            fill_r    <= {FILL_W{1'b0}};
            pattern_r <= PATTERN;
            overlap_r <= OVERLAP;
            ostream_r <= 1'b0;
        end else if (cfg_load) begin
            // A load restarts detection; a bit presented in the same cycle is dropped.
            hist_r    <= {PLEN{1'b0}};
            fill_r    <= {FILL_W{1'b0}};
            pattern_r <= cfg_pattern;
            overlap_r <= cfg_overlap;
            ostream_r <= 1'b0;
        end else if (in_valid) begin
            hist_r    <= next_s;
            fill_r    <= fill_nxt_s;
            ostream_r <= hit_s;
        end else begin
            ostream_r <= 1'b0;
        end
    end

    // Saturating match counter; clear wins over a hit in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            match_cnt_r <= {CNT_W{1'b0}};
        end else if (hit_s && (match_cnt_r != CNT_MAX_C)) begin
            match_cnt_r <= match_cnt_r + CNT_W'(1);
        end else begin
            match_cnt_r <= match_cnt_r;
        end
    end

    assign ostream   = ostream_r;
    assign match_cnt = match_cnt_r;
    assign fill      = fill_r;

endmodule
